// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
//   Multiplexed N-digit seven-segment scanner. Hex nibbles and per-digit
//   blink/blank masks are captured into a shadow register on i_load. The
//   display reads only the shadow, so a partially updated input bus never
//   reaches the pins. Refresh and blink timebases are derived from clk.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   i_digits_in    packed nibbles, nibble k = [4k+3:4k], digit 0 rightmost
//   i_blink_mask   bit k = 1: digit k blinks with o_blink_phase
//   i_blank_mask   bit k = 1: digit k is dark
//   i_load         capture digits and masks into the shadow registers
//   o_seg          {g,f,e,d,c,b,a}, registered, polarity per ACTIVE_LOW
//   o_an           one-hot digit enable, registered, polarity per ACTIVE_LOW
//   o_digit_idx    digit currently being scanned
//   o_blink_phase  1 = blinking digits visible
// ---------------------------------------------------------------------------
module seg_scan_mux #(
  parameter int  NUM_DIGITS   = 4,
  parameter int  REFRESH_DIV  = 100000,
  parameter int  BLINK_DIV    = 25000000,
  parameter int  GUARD_CYCLES = 2,
  parameter bit  ACTIVE_LOW   = 1'b1,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] i_digits_in,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  input  logic                    i_load,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [IDX_W-1:0]        o_digit_idx,
  output logic                    o_blink_phase
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  // XOR masks: all-ones flips active-high values to active-low pins, and the
  // same masks are the "everything off" pin values.
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_POL = {7{ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] r_shadow_digits;
  logic [NUM_DIGITS-1:0]   r_shadow_blink;
  logic [NUM_DIGITS-1:0]   r_shadow_blank;

  logic [RW-1:0]           r_refresh_cnt;
  logic [BW-1:0]           r_blink_cnt;
  logic [IDX_W-1:0]        r_digit_idx;
  logic                    r_blink_phase;

  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_refresh_wrap;
  logic                    w_blink_wrap;
  logic                    w_last_digit;
  logic                    w_guard;
  logic [3:0]              w_nibble;
  logic                    w_blink_sel;
  logic                    w_blank_sel;
  logic                    w_dark;
  logic [NUM_DIGITS-1:0]   w_an_on;
  logic [6:0]              w_seg_on;

  // Active-high gfedcba decode.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  assign w_refresh_wrap = (r_refresh_cnt == RW'(REFRESH_DIV - 1));
  assign w_blink_wrap   = (r_blink_cnt == BW'(BLINK_DIV - 1));
  assign w_last_digit   = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));

  // Anti-ghosting window at the start of every slot: anodes and segments
  // both dark while the previous digit's charge drains.
  generate
    if (GUARD_CYCLES > 0) begin : g_guard
      assign w_guard = (r_refresh_cnt < RW'(GUARD_CYCLES));
    end else begin : g_no_guard
      assign w_guard = 1'b0;
    end
  endgenerate

  // Select the scanned digit's nibble and mask bits from the shadow.
  always_comb begin
    w_nibble    = 4'h0;
    w_blink_sel = 1'b0;
    w_blank_sel = 1'b0;
    w_an_on     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_digit_idx == IDX_W'(k)) begin
        w_nibble    = r_shadow_digits[4*k +: 4];
        w_blink_sel = r_shadow_blink[k];
        w_blank_sel = r_shadow_blank[k];
        w_an_on[k]  = ~w_guard;
      end
    end
  end

  // Blank/blink darken only the segments; the anode keeps its slot so the
  // duty cycle of the other digits is unchanged.
  assign w_dark   = w_guard | w_blank_sel | (w_blink_sel & ~r_blink_phase);
  assign w_seg_on = w_dark ? 7'b0000000 : hex_to_seg(w_nibble);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_digits <= '0;
      r_shadow_blink  <= '0;
      r_shadow_blank  <= '0;
    end else if (i_load) begin
      r_shadow_digits <= i_digits_in;
      r_shadow_blink  <= i_blink_mask;
      r_shadow_blank  <= i_blank_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= '0;
    end else if (w_refresh_wrap) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= w_last_digit ? '0 : r_digit_idx + 1'b1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_blink_wrap) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  // Pin register: built from pre-edge scan state, one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= AN_POL;
      r_seg <= SEG_POL;
    end else begin
      r_an  <= w_an_on ^ AN_POL;
      r_seg <= w_seg_on ^ SEG_POL;
    end
  end

  assign o_seg         = r_seg;
  assign o_an          = r_an;
  assign o_digit_idx   = r_digit_idx;
  assign o_blink_phase = r_blink_phase;

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        blink_phase;

  int n_edges  = 0;
  int n_checks = 0;
  int n_pass   = 0;

  // Bench copy of what the shadow registers should hold.
  logic [15:0] sh_digits = 16'h0000;
  logic [3:0]  sh_blink  = 4'h0;
  logic [3:0]  sh_blank  = 4'h0;

  seg_scan_mux #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_DIV   (8),
    .GUARD_CYCLES(1),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_digits_in  (digits_in),
    .i_blink_mask (blink_mask),
    .i_blank_mask (blank_mask),
    .i_load       (load),
    .o_seg        (seg),
    .o_an         (an),
    .o_digit_idx  (digit_idx),
    .o_blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    n_edges++;
  endtask

  // Active-low pin patterns, gfedcba, written out by hand.
  function automatic logic [6:0] seg_lo(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // After edge n (counted from reset release) the pins show the scan state
  // that existed before that edge: slot position (n-1)%4, digit ((n-1)/4)%4.
  function automatic logic [3:0] exp_an(input int n);
    int         pos;
    logic [3:0] oh;
    pos = (n - 1) % 4;
    oh  = 4'b0001 << (((n - 1) / 4) % 4);
    if (pos == 0) return 4'b1111;
    return ~oh;
  endfunction

  function automatic logic [6:0] exp_seg(input int n, input logic [15:0] d,
                                         input logic [3:0] bl, input logic [3:0] bk);
    int idx;
    bit vis;
    idx = ((n - 1) / 4) % 4;
    vis = ((((n - 1) / 8) % 2) == 0);
    if (((n - 1) % 4) == 0) return 7'b1111111;
    if (bk[idx]) return 7'b1111111;
    if (bl[idx] && !vis) return 7'b1111111;
    return seg_lo(d[idx*4 +: 4]);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (an !== 4'b1111) $display("FAIL reset_an: got %b want 1111", an);
      else n_pass++;
      n_checks++;
      if (seg !== 7'b1111111) $display("FAIL reset_seg: got %b want 1111111", seg);
      else n_pass++;
      n_checks++;
      if (blink_phase !== 1'b1) $display("FAIL reset_phase: got %b want 1", blink_phase);
      else n_pass++;
      n_checks++;
      if (digit_idx !== 2'd0) $display("FAIL reset_idx: got %0d want 0", digit_idx);
      else n_pass++;
    end
    reset = 1'b0;
    n_edges = 0;
    tick();
    n_checks++;
    if (an !== 4'b1111) $display("FAIL release_guard_an: got %b want 1111", an);
    else n_pass++;
    tick();
    n_checks++;
    if (an !== 4'b1110) $display("FAIL release_first_an: got %b want 1110", an);
    else n_pass++;
    n_checks++;
    if (seg !== 7'b1000000) $display("FAIL release_first_seg: got %b want 1000000", seg);
    else n_pass++;
  endtask

  task automatic test_scan();
    digits_in = 16'h1234;
    blink_mask = 4'h0;
    blank_mask = 4'h0;
    load = 1'b1;
    tick();
    load = 1'b0;
    sh_digits = 16'h1234; sh_blink = 4'h0; sh_blank = 4'h0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (an !== exp_an(n_edges))
        $display("FAIL scan_an edge %0d: got %b want %b", n_edges, an, exp_an(n_edges));
      else n_pass++;
      n_checks++;
      if (seg !== exp_seg(n_edges, sh_digits, sh_blink, sh_blank))
        $display("FAIL scan_seg edge %0d: got %b want %b", n_edges, seg,
                 exp_seg(n_edges, sh_digits, sh_blink, sh_blank));
      else n_pass++;
      n_checks++;
      if (digit_idx !== 2'((n_edges / 4) % 4))
        $display("FAIL scan_idx edge %0d: got %0d want %0d", n_edges, digit_idx, (n_edges / 4) % 4);
      else n_pass++;
    end
  endtask

  task automatic test_blink();
    blink_mask = 4'b0001;
    load = 1'b1;
    tick();
    load = 1'b0;
    sh_blink = 4'b0001;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_checks++;
      if (blink_phase !== (((n_edges / 8) % 2) == 0))
        $display("FAIL blink_phase edge %0d: got %b want %b", n_edges, blink_phase,
                 (((n_edges / 8) % 2) == 0));
      else n_pass++;
      n_checks++;
      if (seg !== exp_seg(n_edges, sh_digits, sh_blink, sh_blank))
        $display("FAIL blink_seg edge %0d: got %b want %b", n_edges, seg,
                 exp_seg(n_edges, sh_digits, sh_blink, sh_blank));
      else n_pass++;
      n_checks++;
      if (an !== exp_an(n_edges))
        $display("FAIL blink_an edge %0d: got %b want %b", n_edges, an, exp_an(n_edges));
      else n_pass++;
    end
  endtask

  task automatic test_blank();
    digits_in = 16'hF00A;
    blink_mask = 4'h0;
    blank_mask = 4'b1000;
    load = 1'b1;
    tick();
    load = 1'b0;
    sh_digits = 16'hF00A; sh_blink = 4'h0; sh_blank = 4'b1000;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (an !== exp_an(n_edges))
        $display("FAIL blank_an edge %0d: got %b want %b", n_edges, an, exp_an(n_edges));
      else n_pass++;
      n_checks++;
      if (seg !== exp_seg(n_edges, sh_digits, sh_blink, sh_blank))
        $display("FAIL blank_seg edge %0d: got %b want %b", n_edges, seg,
                 exp_seg(n_edges, sh_digits, sh_blink, sh_blank));
      else n_pass++;
    end
  endtask

  task automatic test_shadow();
    int pre;
    for (int i = 0; i < 16; i++) begin
      digits_in  = 16'($urandom);
      blank_mask = 4'($urandom);
      blink_mask = 4'($urandom);
      tick();
      n_checks++;
      if (seg !== exp_seg(n_edges, sh_digits, sh_blink, sh_blank))
        $display("FAIL noload_seg edge %0d: got %b want %b", n_edges, seg,
                 exp_seg(n_edges, sh_digits, sh_blink, sh_blank));
      else n_pass++;
    end
    // Place the load edge in the middle of a slot so the load edge and the
    // following edge both light the same digit.
    pre = (5 - (n_edges % 4)) % 4;
    for (int i = 0; i < pre; i++) tick();
    digits_in = 16'h8888;
    blink_mask = 4'h0;
    blank_mask = 4'h0;
    load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (seg !== exp_seg(n_edges, sh_digits, sh_blink, sh_blank))
      $display("FAIL load_edge_seg edge %0d: got %b want %b", n_edges, seg,
               exp_seg(n_edges, sh_digits, sh_blink, sh_blank));
    else n_pass++;
    sh_digits = 16'h8888; sh_blink = 4'h0; sh_blank = 4'h0;
    tick();
    n_checks++;
    if (seg !== 7'b0000000) $display("FAIL load_next_seg: got %b want 0000000", seg);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (seg !== exp_seg(n_edges, sh_digits, sh_blink, sh_blank))
        $display("FAIL load_after_seg edge %0d: got %b want %b", n_edges, seg,
                 exp_seg(n_edges, sh_digits, sh_blink, sh_blank));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_scan();
    int pre;
    pre = (26 - (n_edges % 16)) % 16;
    for (int i = 0; i < pre; i++) tick();
    n_checks++;
    if (an !== 4'b1011) $display("FAIL midscan_digit2_an: got %b want 1011", an);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_edges = 0;
    sh_digits = 16'h0000; sh_blink = 4'h0; sh_blank = 4'h0;
    n_checks++;
    if (an !== 4'b1111) $display("FAIL midreset_an: got %b want 1111", an);
    else n_pass++;
    n_checks++;
    if (seg !== 7'b1111111) $display("FAIL midreset_seg: got %b want 1111111", seg);
    else n_pass++;
    n_checks++;
    if (digit_idx !== 2'd0) $display("FAIL midreset_idx: got %0d want 0", digit_idx);
    else n_pass++;
    n_checks++;
    if (blink_phase !== 1'b1) $display("FAIL midreset_phase: got %b want 1", blink_phase);
    else n_pass++;
    tick();
    n_checks++;
    if (an !== 4'b1111) $display("FAIL midreset_guard_an: got %b want 1111", an);
    else n_pass++;
    tick();
    n_checks++;
    if (an !== 4'b1110) $display("FAIL midreset_restart_an: got %b want 1110", an);
    else n_pass++;
    n_checks++;
    if (seg !== 7'b1000000) $display("FAIL midreset_cleared_seg: got %b want 1000000", seg);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (an !== exp_an(n_edges))
        $display("FAIL midreset_full_slot_an edge %0d: got %b want %b", n_edges, an, exp_an(n_edges));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blink();
    test_blank();
    test_shadow();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
